lfsr_rng_range: RTL and testbench

- Parametrised Fibonacci LFSR random source: configurable width, tap mask and seed.
- Request/valid handshake; returns a number uniformly bounded to [0, range_max] by mask-and-reject.
- Supports runtime reseeding and all-zero lock-up recovery.
- Feeds game/logic blocks that need bounded random values (positions, delays, choices) on demand.

---
 rtl/lfsr_rng_range.sv | 116 +++++++++++
 tb/tb_lfsr_rng_range.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_range.sv
// Fibonacci LFSR random source returning values bounded to [0, range_max] by mask-and-reject.
// Optional draw/reject statistics counters are enabled with LFSR_RNG_STATS_EN.
module lfsr_rng_range #(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(8'h0F)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic [WIDTH-1:0] range_max,
  output logic             busy,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd
`ifdef LFSR_RNG_STATS_EN
  ,
  output logic [15:0]      draw_count,
  output logic [15:0]      reject_count
`endif
);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] bound;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] mask_c;
  logic [WIDTH-1:0] cand_c;
  logic             fb_c;
  logic             eval_c;
  logic             accept_c;

  assign fb_c     = ^(lfsr & TAPS);
  assign cand_c   = lfsr & mask;
  assign eval_c   = (state == DRAW) && !seed_load;
  assign accept_c = eval_c && (cand_c <= bound);

  // Smear the highest set bit downwards: smallest 2^k-1 covering range_max.
  always_comb begin
    mask_c = range_max;
    for (int i = 1; i < int'(WIDTH); i++) begin
      mask_c = mask_c | (mask_c >> i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr      <= SEED;
      state     <= IDLE;
      busy      <= 1'b0;
      rnd_valid <= 1'b0;
      rnd       <= '0;
      bound     <= '0;
      mask      <= '0;
    end else begin
      rnd_valid <= 1'b0;

      if (seed_load) begin
        lfsr <= (seed_in == '0) ? SEED : seed_in;
      end else if (lfsr == '0) begin
        lfsr <= SEED;
      end else begin
        lfsr <= {lfsr[WIDTH-2:0], fb_c};
      end

      case (state)
        IDLE: begin
          if (req) begin
            bound <= range_max;
            mask  <= mask_c;
            state <= DRAW;
            busy  <= 1'b1;
          end
        end
        DRAW: begin
          // Candidate uses the pre-advance LFSR value; a seed_load edge skips evaluation.
          if (accept_c) begin
            rnd       <= cand_c;
            rnd_valid <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LFSR_RNG_STATS_EN
  logic reject_c;

  assign reject_c = eval_c && !(cand_c <= bound);

  // Saturating statistics, cleared by reset or reseed.
  always_ff @(posedge clock) begin
    if (reset || seed_load) begin
      draw_count   <= '0;
      reject_count <= '0;
    end else begin
      if (accept_c && (draw_count != 16'hFFFF)) begin
        draw_count <= draw_count + 16'd1;
      end
      if (reject_c && (reject_count != 16'hFFFF)) begin
        reject_count <= reject_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_rng_range.sv
// Self-checking bench for lfsr_rng_range: behavioural model plus per-cycle comparison.
// Counter checks are included when LFSR_RNG_STATS_EN is defined.
module tb_lfsr_rng_range;

  localparam logic [7:0] TAPS = 8'hB8;
  localparam logic [7:0] SEED = 8'h0F;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       seed_load = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic       req = 1'b0;
  logic [7:0] range_max = 8'h00;
  logic       busy;
  logic       rnd_valid;
  logic [7:0] rnd;
`ifdef LFSR_RNG_STATS_EN
  logic [15:0] draw_count;
  logic [15:0] reject_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  lfsr_rng_range dut (
    .clock(clock),
    .reset(reset),
    .seed_load(seed_load),
    .seed_in(seed_in),
    .req(req),
    .range_max(range_max),
    .busy(busy),
    .rnd_valid(rnd_valid),
    .rnd(rnd)
`ifdef LFSR_RNG_STATS_EN
    ,
    .draw_count(draw_count),
    .reject_count(reject_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next LFSR value: shift left, new LSB is the parity of the tapped bits.
  function automatic logic [7:0] step(input logic [7:0] x);
    int ones = 0;
    for (int i = 0; i < 8; i++) begin
      if (x[i] && TAPS[i]) ones++;
    end
    return 8'(({24'd0, x} << 1) | 32'(ones % 2));
  endfunction

  // Smallest 2^k-1 that is >= r.
  function automatic logic [7:0] mask_of(input logic [7:0] r);
    int m = 0;
    while (m < int'(r)) m = m * 2 + 1;
    return 8'(m);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Behavioural model.
  bit         started = 1'b0;
  logic [7:0] m_lfsr = 8'h00;
  logic       m_busy = 1'b0;
  logic       m_valid = 1'b0;
  logic [7:0] m_rnd = 8'h00;
  logic [7:0] m_bound = 8'h00;
  logic [7:0] m_mask = 8'h00;
`ifdef LFSR_RNG_STATS_EN
  logic [15:0] m_dc = 16'h0;
  logic [15:0] m_rc = 16'h0;
`endif

  always @(posedge clock) begin
    if (reset) begin
      started <= 1'b1;
      m_lfsr  <= SEED;
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_rnd   <= 8'h00;
      m_bound <= 8'h00;
      m_mask  <= 8'h00;
`ifdef LFSR_RNG_STATS_EN
      m_dc <= 16'h0;
      m_rc <= 16'h0;
`endif
    end else begin
      m_valid <= 1'b0;
      if (seed_load) m_lfsr <= (seed_in == 8'h00) ? SEED : seed_in;
      else if (m_lfsr == 8'h00) m_lfsr <= SEED;
      else m_lfsr <= step(m_lfsr);

      if (!m_busy) begin
        if (req) begin
          m_busy  <= 1'b1;
          m_bound <= range_max;
          m_mask  <= mask_of(range_max);
        end
      end else if (!seed_load) begin
        if ((m_lfsr & m_mask) <= m_bound) begin
          m_rnd   <= m_lfsr & m_mask;
          m_valid <= 1'b1;
          m_busy  <= 1'b0;
`ifdef LFSR_RNG_STATS_EN
          m_dc <= sat_inc(m_dc);
        end else begin
          m_rc <= sat_inc(m_rc);
`endif
        end
      end
`ifdef LFSR_RNG_STATS_EN
      if (seed_load) begin
        m_dc <= 16'h0;
        m_rc <= 16'h0;
      end
`endif
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (started) begin
      check("lfsr", 32'(dut.lfsr), 32'(m_lfsr));
      check("busy", 32'(busy), 32'(m_busy));
      check("rnd_valid", 32'(rnd_valid), 32'(m_valid));
      check("rnd", 32'(rnd), 32'(m_rnd));
`ifdef LFSR_RNG_STATS_EN
      check("draw_count", 32'(draw_count), 32'(m_dc));
      check("reject_count", 32'(reject_count), 32'(m_rc));
`endif
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req = 1'b0;
    seed_load = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Start a draw (already idle) and wait for its result within a cycle budget.
  task automatic random_draw(input logic [7:0] bound_in, input bit jitter,
                             output bit got, output logic [7:0] val);
    got = 1'b0;
    val = 8'h00;
    req = 1'b1;
    range_max = bound_in;
    tick;
    req = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      if (jitter) begin
        seed_load = ($urandom_range(0, 15) == 0);
        seed_in = 8'($urandom);
        if ($urandom_range(0, 3) == 0) seed_in = 8'h00;
        req = 1'($urandom_range(0, 1));
        range_max = 8'($urandom);
      end
      tick;
      if (rnd_valid) begin
        got = 1'b1;
        val = rnd;
      end
    end
    req = 1'b0;
    seed_load = 1'b0;
    if (!got) check("draw_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
    $fatal(1);
  end

  initial begin
    bit         got;
    logic [7:0] val;
    bit         seen [6];
    int         over;
    bit         any_zero;
    bit         early;
    int         vcount;

    // Reset values and first LFSR steps.
    do_reset;
    check("reset_lfsr", 32'(dut.lfsr), 32'h0F);
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_valid", 32'(rnd_valid), 32'(0));
    check("reset_rnd", 32'(rnd), 32'(0));
    tick; check("lfsr_step1", 32'(dut.lfsr), 32'h1F);
    tick; check("lfsr_step2", 32'(dut.lfsr), 32'h3E);
    tick; check("lfsr_step3", 32'(dut.lfsr), 32'h7D);

    // Full period: back to the seed after exactly 255 advances, never zero.
    do_reset;
    any_zero = 1'b0;
    early = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      tick;
      if (dut.lfsr == 8'h00) any_zero = 1'b1;
      if (i < 255 && dut.lfsr == SEED) early = 1'b1;
    end
    check("period_end", 32'(dut.lfsr), 32'h0F);
    check("period_nonzero", 32'(any_zero), 32'(0));
    check("period_exact", 32'(early), 32'(0));

    // Full-range draw accepted in one cycle.
    do_reset;
    req = 1'b1; range_max = 8'hFF;
    tick; req = 1'b0;
    check("ff_busy", 32'(busy), 32'(1));
    check("ff_valid_early", 32'(rnd_valid), 32'(0));
    tick;
    check("ff_rnd", 32'(rnd), 32'h1F);
    check("ff_valid", 32'(rnd_valid), 32'(1));
    check("ff_busy_done", 32'(busy), 32'(0));
    tick;
    check("ff_valid_pulse", 32'(rnd_valid), 32'(0));

    // range_max=3 accepted immediately.
    do_reset;
    req = 1'b1; range_max = 8'd3;
    tick; req = 1'b0;
    tick;
    check("r3_valid", 32'(rnd_valid), 32'(1));
    check("r3_rnd", 32'(rnd), 32'(3));

    // range_max=2: candidate 3 rejected, then 2 from 8'h3E.
    do_reset;
    req = 1'b1; range_max = 8'd2;
    tick; req = 1'b0;
    tick;
    check("r2_reject_busy", 32'(busy), 32'(1));
    check("r2_reject_valid", 32'(rnd_valid), 32'(0));
    tick;
    check("r2_valid", 32'(rnd_valid), 32'(1));
    check("r2_rnd", 32'(rnd), 32'(2));
`ifdef LFSR_RNG_STATS_EN
    check("r2_reject_count", 32'(reject_count), 32'(1));
    check("r2_draw_count", 32'(draw_count), 32'(1));
`endif

    // Reseeding while idle.
    do_reset;
    seed_load = 1'b1; seed_in = 8'h00;
    tick; seed_load = 1'b0;
    check("seed_zero", 32'(dut.lfsr), 32'h0F);
    seed_load = 1'b1; seed_in = 8'hA5;
    tick; seed_load = 1'b0;
    check("seed_a5", 32'(dut.lfsr), 32'hA5);
    tick;
    check("seed_a5_step", 32'(dut.lfsr), 32'h4A);

    // Reseed during DRAW delays acceptance by one cycle.
    do_reset;
    req = 1'b1; range_max = 8'hFF;
    tick; req = 1'b0;
    seed_load = 1'b1; seed_in = 8'hA5;
    tick; seed_load = 1'b0;
    check("sdraw_busy", 32'(busy), 32'(1));
    check("sdraw_no_valid", 32'(rnd_valid), 32'(0));
    tick;
    check("sdraw_valid", 32'(rnd_valid), 32'(1));
    check("sdraw_rnd", 32'(rnd), 32'hA5);

    // req held and range_max changed while busy: ignored.
    do_reset;
    req = 1'b1; range_max = 8'd2;
    tick;
    range_max = 8'hFF;
    tick;
    check("busy_ignore_reject", 32'(rnd_valid), 32'(0));
    tick;
    req = 1'b0;
    check("busy_ignore_valid", 32'(rnd_valid), 32'(1));
    check("busy_ignore_rnd", 32'(rnd), 32'(2));
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (rnd_valid) vcount++;
    end
    check("busy_ignore_single", 32'(vcount), 32'(0));

    // Bound 0, then reset mid-DRAW aborts without a result.
    do_reset;
    req = 1'b1; range_max = 8'hFF;
    tick; req = 1'b0;
    tick;
    check("pre_abort_rnd", 32'(rnd), 32'h1F);
    req = 1'b1; range_max = 8'h00;
    tick; req = 1'b0;
    tick;
    check("zero_valid", 32'(rnd_valid), 32'(1));
    check("zero_rnd", 32'(rnd), 32'(0));
    req = 1'b1; range_max = 8'hFF;
    tick; req = 1'b0;
    tick;
    req = 1'b1; range_max = 8'hFF;
    tick; req = 1'b0;
    check("abort_busy_before", 32'(busy), 32'(1));
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_rnd", 32'(rnd), 32'(0));
    check("abort_valid", 32'(rnd_valid), 32'(0));
    tick;
    check("abort_no_valid", 32'(rnd_valid), 32'(0));

    // 1000 bounded draws with random disturbances.
    for (int i = 0; i < 6; i++) seen[i] = 1'b0;
    over = 0;
    for (int d = 0; d < 1000; d++) begin
      random_draw(8'd5, 1'b1, got, val);
      if (got) begin
        if (val > 8'd5) over++;
        else seen[val] = 1'b1;
      end
    end
    check("bound5_over", 32'(over), 32'(0));
    for (int i = 0; i < 6; i++) check($sformatf("bound5_seen_%0d", i), 32'(seen[i]), 32'(1));

    // Random bounds, checked cycle by cycle against the model.
    for (int d = 0; d < 200; d++) begin
      random_draw(8'($urandom), 1'($urandom_range(0, 1)), got, val);
    end

    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
